// File: rtl/wb_commit_stage.sv
// Dual-lane writeback commit stage: registers lane results onto the two register-file write
// ports and merges long-latency results from a small FIFO into free slots. WB_LU_BYPASS_EN enables same-cycle FIFO bypass.
module wb_commit_stage #(
  parameter int LU_DEPTH     = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_valid0,
  input  logic        m_valid1,
  input  logic [4:0]  m_rd0,
  input  logic [4:0]  m_rd1,
  input  logic [31:0] m_data0,
  input  logic [31:0] m_data1,
  input  logic        m_order_change,
  input  logic        lu_valid,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  output logic        stall_m,
  output logic        WE3,
  output logic [4:0]  A3,
  output logic [31:0] WD3,
  output logic        WE3_2,
  output logic [4:0]  A3_2,
  output logic [31:0] WD3_2,
  output logic        order_change_w
);

  localparam int PTRW = $clog2(LU_DEPTH);
  localparam int CNTW = PTRW + 1;
  localparam int STW  = $clog2(STARVE_LIMIT + 1);

  logic [4:0]      fifo_rd   [LU_DEPTH];
  logic [31:0]     fifo_data [LU_DEPTH];
  logic [PTRW-1:0] rd_ptr;
  logic [PTRW-1:0] wr_ptr;
  logic [CNTW-1:0] count;
  logic [STW-1:0]  starve_cnt;

  logic            occ0;
  logic            occ1;
  logic [4:0]      head_rd;
  logic [31:0]     head_data;
  logic [4:0]      next_rd;
  logic [31:0]     next_data;
  logic            head_conflict;
  logic            head_drain;
  logic            next_drain;
  logic            bypass;
  logic            push;
  logic [1:0]      pop_cnt;
  logic            we1_d;
  logic            we2_d;
  logic [4:0]      a1_d;
  logic [4:0]      a2_d;
  logic [31:0]     d1_d;
  logic [31:0]     d2_d;

  assign lu_ready = (count < CNTW'(LU_DEPTH));
  assign stall_m  = (starve_cnt == STW'(STARVE_LIMIT));

  assign occ0 = m_valid0 && (m_rd0 != 5'd0) && !stall_m;
  assign occ1 = m_valid1 && (m_rd1 != 5'd0) && !stall_m;

  assign head_rd   = fifo_rd[rd_ptr];
  assign head_data = fifo_data[rd_ptr];
  assign next_rd   = fifo_rd[rd_ptr + PTRW'(1)];
  assign next_data = fifo_data[rd_ptr + PTRW'(1)];

  assign head_conflict = (occ0 && (head_rd == m_rd0)) || (occ1 && (head_rd == m_rd1));

`ifdef WB_LU_BYPASS_EN
  logic lu_conflict;
  assign lu_conflict = (occ0 && (lu_rd == m_rd0)) || (occ1 && (lu_rd == m_rd1));
`endif

  // Head+1 can only drain when both slots are free, so no lane can conflict with it.
  always_comb begin
    head_drain = (count != '0) && !(occ0 && occ1) && !head_conflict;
    next_drain = head_drain && (count >= CNTW'(2)) && !occ0 && !occ1;

    we1_d = occ0;
    a1_d  = m_rd0;
    d1_d  = m_data0;
    we2_d = occ1;
    a2_d  = m_rd1;
    d2_d  = m_data1;

    if (head_drain) begin
      if (!occ0) begin
        we1_d = 1'b1;
        a1_d  = head_rd;
        d1_d  = head_data;
      end else begin
        we2_d = 1'b1;
        a2_d  = head_rd;
        d2_d  = head_data;
      end
    end
    if (next_drain) begin
      we2_d = 1'b1;
      a2_d  = next_rd;
      d2_d  = next_data;
    end

    bypass = 1'b0;
`ifdef WB_LU_BYPASS_EN
    if ((count == '0) && lu_valid && !(occ0 && occ1) && !lu_conflict) begin
      bypass = 1'b1;
      if (!occ0) begin
        we1_d = 1'b1;
        a1_d  = lu_rd;
        d1_d  = lu_data;
      end else begin
        we2_d = 1'b1;
        a2_d  = lu_rd;
        d2_d  = lu_data;
      end
    end
`endif

    push    = lu_valid && lu_ready && !bypass;
    pop_cnt = {1'b0, head_drain} + {1'b0, next_drain};
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= lu_rd;
      fifo_data[wr_ptr] <= lu_data;
    end
  end

  // The counter saturates at the limit; reaching it frees both slots so the head always drains next.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
    end else begin
      rd_ptr <= rd_ptr + PTRW'(pop_cnt);
      if (push) wr_ptr <= wr_ptr + PTRW'(1);
      count <= count + CNTW'(push) - CNTW'(pop_cnt);
      if ((count == '0) || head_drain) starve_cnt <= '0;
      else if (!stall_m)               starve_cnt <= starve_cnt + STW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      WE3            <= 1'b0;
      A3             <= '0;
      WD3            <= '0;
      WE3_2          <= 1'b0;
      A3_2           <= '0;
      WD3_2          <= '0;
      order_change_w <= 1'b0;
    end else begin
      WE3            <= we1_d;
      A3             <= a1_d;
      WD3            <= d1_d;
      WE3_2          <= we2_d;
      A3_2           <= a2_d;
      WD3_2          <= d2_d;
      order_change_w <= occ0 && occ1 && m_order_change;
    end
  end

endmodule
